// File: rtl/hazard_stall_pkg.sv
// Shared CPU definitions: D/X control-word field positions
// and the multdiv sequencer state encoding.
package hazard_stall_pkg;

  localparam int RD_HI      = 31;
  localparam int RD_LO      = 27;
  localparam int RWE        = 15;
  localparam int MEM_TO_REG = 13;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/hazard_stall_md_sequencer.sv
// Multdiv sequencer: start pulse, front-end freeze,
// result hand-off and timeout for one mul/div in D/X.
module md_sequencer
  import hazard_stall_pkg::*;
#(
  parameter int MD_TIMEOUT = 40
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dx_is_mult,
  input  logic dx_is_div,
  input  logic md_ready,
  input  logic md_exception,
  output logic md_start_mult,
  output logic md_start_div,
  output logic md_stall,
  output logic md_busy,
  output logic md_wb_valid,
  output logic md_exc,
  output logic md_timeout,
  output logic md_idle
);

  localparam int CW = $clog2(MD_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(MD_TIMEOUT - 1);

  md_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          go;

  // No new operation may launch while reset is held.
  assign go = rst_n & (dx_is_mult | dx_is_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    md_start_mult = 1'b0;
    md_start_div  = 1'b0;
    md_stall      = 1'b0;
    md_busy       = 1'b0;
    md_wb_valid   = 1'b0;
    md_exc        = 1'b0;
    md_timeout    = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (go) begin
          md_start_mult = dx_is_mult;
          md_start_div  = dx_is_div;
          md_stall      = 1'b1;
          md_busy       = 1'b1;
          cnt_d         = '0;
          state_d       = MD_RUN;
        end
      end
      MD_RUN: begin
        if (md_ready) begin
          md_wb_valid = 1'b1;
          md_exc      = md_exception;
          cnt_d       = '0;
          state_d     = MD_IDLE;
        end else if (cnt_q == LAST) begin
          md_timeout = 1'b1;
          cnt_d      = '0;
          state_d    = MD_IDLE;
        end else begin
          md_stall = 1'b1;
          md_busy  = 1'b1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign md_idle = (state_q == MD_IDLE);

endmodule

// File: rtl/hazard_stall.sv
// Pipeline interlock: load-use bubble insertion and
// multdiv freeze, driving latch enables and NOP inserts.
module hazard_stall
  import hazard_stall_pkg::*;
#(
  parameter int MD_TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ctrl_dx,
  input  logic        dx_is_mult,
  input  logic        dx_is_div,
  input  logic [4:0]  fd_rs,
  input  logic [4:0]  fd_rt,
  input  logic        fd_rs_used,
  input  logic        fd_rt_used,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        stall_pc,
  output logic        stall_fd,
  output logic        stall_dx,
  output logic        bubble_dx,
  output logic        bubble_xm,
  output logic        md_start_mult,
  output logic        md_start_div,
  output logic        md_busy,
  output logic        md_wb_valid,
  output logic        md_exc,
  output logic        md_timeout
);

  logic [4:0] ld_rd;
  logic       is_load;
  logic       rs_hit;
  logic       rt_hit;
  logic       lu_stall;
  logic       md_stall;
  logic       md_idle;
  logic       unused_ctrl;

  assign unused_ctrl = ^{ctrl_dx[26:16], ctrl_dx[14], ctrl_dx[12:0]};

  md_sequencer #(
    .MD_TIMEOUT(MD_TIMEOUT)
  ) u_seq (
    .clk          (clock),
    .rst_n        (reset),
    .dx_is_mult   (dx_is_mult),
    .dx_is_div    (dx_is_div),
    .md_ready     (md_ready),
    .md_exception (md_exception),
    .md_start_mult(md_start_mult),
    .md_start_div (md_start_div),
    .md_stall     (md_stall),
    .md_busy      (md_busy),
    .md_wb_valid  (md_wb_valid),
    .md_exc       (md_exc),
    .md_timeout   (md_timeout),
    .md_idle      (md_idle)
  );

  assign ld_rd   = ctrl_dx[RD_HI:RD_LO];
  assign is_load = ctrl_dx[MEM_TO_REG] & ctrl_dx[RWE]
                 & (ld_rd != 5'd0);
  assign rs_hit  = fd_rs_used & (fd_rs == ld_rd);
  assign rt_hit  = fd_rt_used & (fd_rt == ld_rd);

  // A mul/div in D/X owns the pipeline; load-use is masked.
  assign lu_stall = reset & md_idle
                  & ~dx_is_mult & ~dx_is_div
                  & is_load & (rs_hit | rt_hit);

  always_comb begin
    stall_pc  = 1'b0;
    stall_fd  = 1'b0;
    stall_dx  = 1'b0;
    bubble_dx = 1'b0;
    bubble_xm = 1'b0;
    if (md_stall) begin
      stall_pc  = 1'b1;
      stall_fd  = 1'b1;
      stall_dx  = 1'b1;
      bubble_xm = 1'b1;
    end else if (lu_stall) begin
      stall_pc  = 1'b1;
      stall_fd  = 1'b1;
      bubble_dx = 1'b1;
    end
  end

endmodule
